// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Micro-step sequencer for the multicycle RV32I core. It holds the current
//   step (IF/ID/EX/MEM/WB/HALT) and the latched opcode, steps each instruction
//   class through its micro-steps, stalls on memory handshakes, and tracks
//   cycle/retired counters plus illegal-opcode and memory-timeout faults.
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   ir_opcode     opcode field of the instruction register (valid from ID)
//   mem_ready     memory access complete (sampled in IF and MEM)
//   halt_cond     ecall halt qualifier (sampled in ID)
//   state         current step: IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5
//   part_of_inst  opcode to control unit (live in ID, latched otherwise)
//   inst_done     pulse on the final step of each retired instruction
//   is_halted     high while in HALT
//   illegal_inst  pulse on an unknown opcode in ID
//   mem_timeout   sticky memory-timeout fault, cleared only by reset
//   cycle_count   cycles spent outside HALT
//   retired_count instructions retired
module multicycle_sequencer #(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           ir_opcode,
    input  logic                 mem_ready,
    input  logic                 halt_cond,
    output logic [2:0]           state,
    output logic [6:0]           part_of_inst,
    output logic                 inst_done,
    output logic                 is_halted,
    output logic                 illegal_inst,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] retired_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
    // Last wait count before the fault fires; meaningless when timeout is off.
    localparam logic [WAIT_W-1:0] waitLast   = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic              timeoutEn  = (MEM_TIMEOUT > 0);

    localparam logic [6:0] opR      = 7'b0110011;
    localparam logic [6:0] opIArith = 7'b0010011;
    localparam logic [6:0] opLoad   = 7'b0000011;
    localparam logic [6:0] opStore  = 7'b0100011;
    localparam logic [6:0] opBranch = 7'b1100011;
    localparam logic [6:0] opJal    = 7'b1101111;
    localparam logic [6:0] opJalr   = 7'b1100111;
    localparam logic [6:0] opLui    = 7'b0110111;
    localparam logic [6:0] opAuipc  = 7'b0010111;
    localparam logic [6:0] opSystem = 7'b1110011;

    typedef enum logic [2:0] {
        stIf   = 3'd0,
        stId   = 3'd1,
        stEx   = 3'd2,
        stMem  = 3'd3,
        stWb   = 3'd4,
        stHalt = 3'd5
    } stepE;

    stepE              curState;
    stepE              nextState;
    logic [6:0]        opcodeQ;
    logic [WAIT_W-1:0] waitCnt;
    logic              memWait;
    logic              timeoutHit;

    assign state        = curState;
    assign is_halted    = (curState == stHalt);
    assign part_of_inst = (curState == stId) ? ir_opcode : opcodeQ;

    // Next-step selection; inst_done/illegal_inst are decoded here as well
    // because they depend on the same state/input combination.
    always_comb begin
        nextState    = curState;
        inst_done    = 1'b0;
        illegal_inst = 1'b0;
        memWait      = ((curState == stIf) || (curState == stMem)) && !mem_ready;
        timeoutHit   = timeoutEn && memWait && (waitCnt == waitLast);

        case (curState)
            stIf: begin
                if (mem_ready)       nextState = stId;
                else if (timeoutHit) nextState = stHalt;
            end
            stId: begin
                case (ir_opcode)
                    opR, opIArith, opLoad, opStore, opBranch,
                    opJal, opJalr, opLui, opAuipc: nextState = stEx;
                    opSystem: begin
                        inst_done = 1'b1;
                        nextState = halt_cond ? stHalt : stIf;
                    end
                    default: begin
                        illegal_inst = 1'b1;
                        nextState    = stIf;
                    end
                endcase
            end
            stEx: begin
                case (opcodeQ)
                    opLoad, opStore: nextState = stMem;
                    opBranch: begin
                        inst_done = 1'b1;
                        nextState = stIf;
                    end
                    default: nextState = stWb;
                endcase
            end
            stMem: begin
                if (mem_ready) begin
                    if (opcodeQ == opLoad) begin
                        nextState = stWb;
                    end else begin
                        inst_done = 1'b1;
                        nextState = stIf;
                    end
                end else if (timeoutHit) begin
                    nextState = stHalt;
                end
            end
            stWb: begin
                inst_done = 1'b1;
                nextState = stIf;
            end
            stHalt:  nextState = stHalt;
            default: nextState = stIf;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            curState      <= stIf;
            opcodeQ       <= '0;
            waitCnt       <= '0;
            mem_timeout   <= 1'b0;
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            curState <= nextState;

            if (curState == stId) opcodeQ <= ir_opcode;

            if (nextState != curState) waitCnt <= '0;
            else if (memWait)          waitCnt <= waitCnt + 1'b1;

            if (timeoutHit) mem_timeout <= 1'b1;

            if (curState != stHalt) cycle_count <= cycle_count + 1'b1;
            if (inst_done)          retired_count <= retired_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer
//   Scoreboard bench for multicycle_sequencer (CNT_WIDTH=32, MEM_TIMEOUT=4).
//   The stimulus process drives one cycle at a time and queues the values the
//   DUT must show during that cycle; the monitor pops and compares on the
//   falling edge.
module tb_multicycle_sequencer;

    localparam logic [6:0] opR      = 7'b0110011;
    localparam logic [6:0] opLoad   = 7'b0000011;
    localparam logic [6:0] opStore  = 7'b0100011;
    localparam logic [6:0] opBranch = 7'b1100011;
    localparam logic [6:0] opSystem = 7'b1110011;
    localparam logic [6:0] opIll    = 7'b1111111;

    logic        clk;
    logic        reset_n;
    logic [6:0]  irOpcode;
    logic        memReady;
    logic        haltCond;
    logic [2:0]  state;
    logic [6:0]  partOfInst;
    logic        instDone;
    logic        isHalted;
    logic        illegalInst;
    logic        memTimeout;
    logic [31:0] cycleCount;
    logic [31:0] retiredCount;

    multicycle_sequencer #(
        .CNT_WIDTH  (32),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ir_opcode    (irOpcode),
        .mem_ready    (memReady),
        .halt_cond    (haltCond),
        .state        (state),
        .part_of_inst (partOfInst),
        .inst_done    (instDone),
        .is_halted    (isHalted),
        .illegal_inst (illegalInst),
        .mem_timeout  (memTimeout),
        .cycle_count  (cycleCount),
        .retired_count(retiredCount)
    );

    typedef struct {
        logic [2:0]  st;
        logic        done;
        logic        ill;
        logic        tmo;
        logic [6:0]  poi;
        logic [31:0] ret;
        logic [31:0] cyc;
        string       nm;
    } expT;

    expT sb[$];
    int  checks = 0;
    int  errors = 0;
    int unsigned expRet = 0;
    int unsigned expCyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        expT e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(e.nm, "state",         32'(state),        32'(e.st));
            chk(e.nm, "inst_done",     32'(instDone),     32'(e.done));
            chk(e.nm, "illegal_inst",  32'(illegalInst),  32'(e.ill));
            chk(e.nm, "is_halted",     32'(isHalted),     32'(e.st == 3'd5));
            chk(e.nm, "mem_timeout",   32'(memTimeout),   32'(e.tmo));
            chk(e.nm, "part_of_inst",  32'(partOfInst),   32'(e.poi));
            chk(e.nm, "retired_count", retiredCount,      e.ret);
            chk(e.nm, "cycle_count",   cycleCount,        e.cyc);
        end
    end

    // Called at posedge+1: drive one cycle and queue what the DUT must show.
    task automatic step(input string nm, input logic mr, input logic [6:0] op,
                        input logic hc, input logic [2:0] st, input logic done,
                        input logic ill, input logic tmo, input logic [6:0] poi);
        expT e;
        memReady = mr;
        irOpcode = op;
        haltCond = hc;
        e.st = st; e.done = done; e.ill = ill; e.tmo = tmo; e.poi = poi;
        e.ret = expRet; e.cyc = expCyc; e.nm = nm;
        sb.push_back(e);
        if (done) expRet++;
        if (st != 3'd5) expCyc++;
        @(posedge clk);
        #1;
    endtask

    // Reset asserted at posedge+1; the falling-edge check lands before any
    // rising edge, so zeros there prove the reset acts asynchronously.
    task automatic rst(input string nm);
        expT e;
        reset_n  = 1'b0;
        memReady = 1'b0;
        irOpcode = '0;
        haltCond = 1'b0;
        e.st = 3'd0; e.done = 1'b0; e.ill = 1'b0; e.tmo = 1'b0; e.poi = 7'h00;
        e.ret = 32'd0; e.cyc = 32'd0; e.nm = nm;
        sb.push_back(e);
        expRet = 0;
        expCyc = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        memReady = 1'b0;
        irOpcode = '0;
        haltCond = 1'b0;
        @(posedge clk);
        #1;
        rst("reset0");

        // R-type: IF ID EX WB
        step("r_if",  1, opR, 0, 3'd0, 0, 0, 0, 7'h00);
        step("r_id",  1, opR, 0, 3'd1, 0, 0, 0, opR);
        step("r_ex",  1, opR, 0, 3'd2, 0, 0, 0, opR);
        step("r_wb",  1, opR, 0, 3'd4, 1, 0, 0, opR);

        // LOAD with two MEM stall cycles (first entry sees retired=1, cycles=4)
        step("ld_if",   1, opLoad, 0, 3'd0, 0, 0, 0, opR);
        step("ld_id",   1, opLoad, 0, 3'd1, 0, 0, 0, opLoad);
        step("ld_ex",   1, opLoad, 0, 3'd2, 0, 0, 0, opLoad);
        step("ld_mem0", 0, opLoad, 0, 3'd3, 0, 0, 0, opLoad);
        step("ld_mem1", 0, opLoad, 0, 3'd3, 0, 0, 0, opLoad);
        step("ld_mem2", 1, opLoad, 0, 3'd3, 0, 0, 0, opLoad);
        step("ld_wb",   1, opLoad, 0, 3'd4, 1, 0, 0, opLoad);

        // BRANCH retires in EX, STORE retires in MEM
        step("br_if",  1, opBranch, 0, 3'd0, 0, 0, 0, opLoad);
        step("br_id",  1, opBranch, 0, 3'd1, 0, 0, 0, opBranch);
        step("br_ex",  1, opBranch, 0, 3'd2, 1, 0, 0, opBranch);
        step("st_if",  1, opStore,  0, 3'd0, 0, 0, 0, opBranch);
        step("st_id",  1, opStore,  0, 3'd1, 0, 0, 0, opStore);
        step("st_ex",  1, opStore,  0, 3'd2, 0, 0, 0, opStore);
        step("st_mem", 1, opStore,  0, 3'd3, 1, 0, 0, opStore);

        // Illegal opcode: pulse in ID, back to IF, nothing retired
        step("ill_if", 1, opIll, 0, 3'd0, 0, 0, 0, opStore);
        step("ill_id", 1, opIll, 0, 3'd1, 0, 1, 0, opIll);

        // Fetch stall reaching the timeout count, ready arrives that cycle
        step("rw_if0", 0, opR, 0, 3'd0, 0, 0, 0, opIll);
        step("rw_if1", 0, opR, 0, 3'd0, 0, 0, 0, opIll);
        step("rw_if2", 0, opR, 0, 3'd0, 0, 0, 0, opIll);
        step("rw_if3", 1, opR, 0, 3'd0, 0, 0, 0, opIll);
        step("rw_id",  1, opR, 0, 3'd1, 0, 0, 0, opR);
        step("rw_ex",  1, opR, 0, 3'd2, 0, 0, 0, opR);
        step("rw_wb",  1, opR, 0, 3'd4, 1, 0, 0, opR);
        step("rw_end", 1, opR, 0, 3'd0, 0, 0, 0, opR);

        // ECALL with halt qualifier: HALT after 2 cycles, counters frozen
        rst("reset_ecall");
        step("ec_if", 1, opSystem, 1, 3'd0, 0, 0, 0, 7'h00);
        step("ec_id", 1, opSystem, 1, 3'd1, 1, 0, 0, opSystem);
        for (int i = 0; i < 10; i++)
            step("ec_halt", 1, (i % 2 == 0) ? opSystem : opIll, 1,
                 3'd5, 0, 0, 0, opSystem);

        // Fetch timeout: four stalled IF cycles then HALT with the fault set
        rst("reset_in_halt");
        for (int i = 0; i < 4; i++)
            step("to_if", 0, opR, 0, 3'd0, 0, 0, 0, 7'h00);
        for (int i = 0; i < 3; i++)
            step("to_halt", 1, opR, 0, 3'd5, 0, 0, 1, 7'h00);
        rst("reset_fault");

        // Normal operation after fault recovery
        step("pr_if",  1, opR, 0, 3'd0, 0, 0, 0, 7'h00);
        step("pr_id",  1, opR, 0, 3'd1, 0, 0, 0, opR);
        step("pr_ex",  1, opR, 0, 3'd2, 0, 0, 0, opR);
        step("pr_wb",  1, opR, 0, 3'd4, 1, 0, 0, opR);
        step("pr_end", 1, opR, 0, 3'd0, 0, 0, 0, opR);

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
